dsram_bridge: RTL and testbench

DSRAM_BRIDGE -- requirements
Module: dsram_bridge

---
 rtl/dsram_bridge_pkg.sv | 23 ++
 rtl/dsram_bridge.sv | 98 +++++++++
 tb/tb_dsram_bridge.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dsram_bridge_pkg.sv
// Shared widths, stall encodings and the latched-request record for the data-SRAM bridge.
package dsram_bridge_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-3:0] word_addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Loads read the whole word, so every lane is enabled.
  function automatic logic [BE_W-1:0] lane_mask(input logic [BE_W-1:0] wen);
    return (wen == '0) ? '1 : wen;
  endfunction

endpackage

// File: rtl/dsram_bridge.sv
// Bridges the CPU data-SRAM port onto a req/ack memory bus: loads stall the pipeline
// until ack, stores are posted and only stall a following request while still pending.
module dsram_bridge
  import dsram_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_en,
  input  logic [BE_W-1:0]   data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              stallreq,
  output logic              mem_req,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  req_t              r_req;
  logic [DATA_W-1:0] r_rdata;
  logic              w_load;
  logic              w_accept;
  logic              w_mem_req;
  logic              w_stall;
  logic              w_unused_addr_lsb;

  assign w_load            = (data_sram_wen == '0);
  assign w_accept          = (r_state == IDLE) && data_sram_en;
  assign w_unused_addr_lsb = ^data_sram_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (data_sram_en) w_next = w_load ? RD : WR;
      RD, WR:  if (mem_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // A store in IDLE is posted; only a request colliding with a pending store waits.
  always_comb begin
    w_mem_req = 1'b0;
    w_stall   = NoStop;
    case (r_state)
      IDLE: w_stall = (data_sram_en && w_load) ? Stop : NoStop;
      RD: begin
        w_mem_req = 1'b1;
        w_stall   = mem_ack ? NoStop : Stop;
      end
      WR: begin
        w_mem_req = 1'b1;
        w_stall   = (data_sram_en && !mem_ack) ? Stop : NoStop;
      end
      default: w_stall = NoStop;
    endcase
    if (rst) w_stall = NoStop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req <= '0;
    end else if (w_accept) begin
      r_req.we        <= !w_load;
      r_req.be        <= lane_mask(data_sram_wen);
      r_req.word_addr <= data_sram_addr[ADDR_W-1:2];
      r_req.wdata     <= data_sram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                            r_rdata <= '0;
    else if ((r_state == RD) && mem_ack) r_rdata <= mem_rdata;
  end

  assign data_sram_rdata = r_rdata;
  assign stallreq        = w_stall;
  assign mem_req         = w_mem_req;
  assign mem_we          = r_req.we;
  assign mem_be          = r_req.be;
  assign mem_addr        = {r_req.word_addr, 2'b00};
  assign mem_wdata       = r_req.wdata;

endmodule

// File: tb/tb_dsram_bridge.sv
// Directed cycle table for load/store/reset corners, then random CPU traffic against a transaction model.
module tb_dsram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dsram_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stallreq        (stallreq),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_be          (mem_be),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, en;
    logic [3:0]  wen;
    logic [31:0] addr, wdata;
    logic        ack;
    logic [31:0] mrd;
    logic        e_req, e_st;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_wdata, e_rd;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic r, input logic en, input logic [3:0] wen,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic ack, input logic [31:0] mrd,
                              input logic e_req, input logic e_st, input logic [31:0] e_addr,
                              input logic [3:0] e_be, input logic e_we,
                              input logic [31:0] e_wdata, input logic [31:0] e_rd);
    vec_t v;
    v.rst = r; v.en = en; v.wen = wen; v.addr = addr; v.wdata = wdata; v.ack = ack; v.mrd = mrd;
    v.e_req = e_req; v.e_st = e_st; v.e_addr = e_addr; v.e_be = e_be; v.e_we = e_we;
    v.e_wdata = e_wdata; v.e_rd = e_rd;
    return v;
  endfunction

  // Random-phase reference: one outstanding memory transaction at most.
  logic        m_busy, m_rd, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        cur_vld, cur_acc;
  logic [3:0]  cur_wen;
  logic [31:0] cur_addr, cur_wdata;
  logic        exp_st;
  int          wait_cnt;
  int          loads;

  initial begin
    // Load with ack in the third RD cycle.
    tbl[0]  = mk(1,1,4'h0,32'h1004,0,0,0,                 0,0,0,0,0,0,0);
    tbl[1]  = mk(0,1,4'h0,32'h1004,0,0,0,                 0,1,0,0,0,0,0);
    tbl[2]  = mk(0,1,4'h0,32'h1004,0,0,0,                 1,1,32'h1004,4'hF,0,0,0);
    tbl[3]  = mk(0,1,4'h0,32'h1004,0,0,0,                 1,1,32'h1004,4'hF,0,0,0);
    tbl[4]  = mk(0,1,4'h0,32'h1004,0,1,32'hDEADBEEF,      1,0,32'h1004,4'hF,0,0,0);
    tbl[5]  = mk(0,0,4'h0,0,0,0,0,                        0,0,0,0,0,0,32'hDEADBEEF);
    // Posted halfword store to an unaligned address.
    tbl[6]  = mk(0,1,4'h3,32'h2002,32'h0000ABCD,0,0,      0,0,0,0,0,0,32'hDEADBEEF);
    tbl[7]  = mk(0,0,4'h0,0,0,0,0,                        1,0,32'h2000,4'h3,1,32'h0000ABCD,32'hDEADBEEF);
    tbl[8]  = mk(0,0,4'h0,0,0,0,0,                        1,0,32'h2000,4'h3,1,32'h0000ABCD,32'hDEADBEEF);
    tbl[9]  = mk(0,0,4'h0,0,0,1,32'h12345678,             1,0,32'h2000,4'h3,1,32'h0000ABCD,32'hDEADBEEF);
    tbl[10] = mk(0,0,4'h0,0,0,0,0,                        0,0,0,0,0,0,32'hDEADBEEF);
    // Store acked in its fifth WR cycle, load queued behind it, then acked immediately.
    tbl[11] = mk(0,1,4'hF,32'h3000,32'h55AA55AA,0,0,      0,0,0,0,0,0,32'hDEADBEEF);
    tbl[12] = mk(0,1,4'h0,32'h3008,0,0,0,                 1,1,32'h3000,4'hF,1,32'h55AA55AA,32'hDEADBEEF);
    tbl[13] = mk(0,1,4'h0,32'h3008,0,0,0,                 1,1,32'h3000,4'hF,1,32'h55AA55AA,32'hDEADBEEF);
    tbl[14] = mk(0,1,4'h0,32'h3008,0,0,0,                 1,1,32'h3000,4'hF,1,32'h55AA55AA,32'hDEADBEEF);
    tbl[15] = mk(0,1,4'h0,32'h3008,0,0,0,                 1,1,32'h3000,4'hF,1,32'h55AA55AA,32'hDEADBEEF);
    tbl[16] = mk(0,1,4'h0,32'h3008,0,1,32'h99999999,      1,0,32'h3000,4'hF,1,32'h55AA55AA,32'hDEADBEEF);
    tbl[17] = mk(0,1,4'h0,32'h3008,0,0,0,                 0,1,0,0,0,0,32'hDEADBEEF);
    tbl[18] = mk(0,1,4'h0,32'h3008,0,1,32'hCAFEF00D,      1,0,32'h3008,4'hF,0,0,32'hDEADBEEF);
    tbl[19] = mk(0,0,4'h0,0,0,0,0,                        0,0,0,0,0,0,32'hCAFEF00D);
    // Reset while a load is outstanding, then a stray ack.
    tbl[20] = mk(0,1,4'h0,32'h4000,0,0,0,                 0,1,0,0,0,0,32'hCAFEF00D);
    tbl[21] = mk(0,1,4'h0,32'h4000,0,0,0,                 1,1,32'h4000,4'hF,0,0,32'hCAFEF00D);
    tbl[22] = mk(1,0,4'h0,0,0,0,0,                        1,0,32'h4000,4'hF,0,0,32'hCAFEF00D);
    tbl[23] = mk(0,0,4'h0,0,0,1,32'h11111111,             0,0,0,0,0,0,0);
    tbl[24] = mk(0,0,4'h0,0,0,0,0,                        0,0,0,0,0,0,0);

    rst = 1'b1; data_sram_en = 1'b0; data_sram_wen = '0; data_sram_addr = '0;
    data_sram_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      rst = tbl[i].rst; data_sram_en = tbl[i].en; data_sram_wen = tbl[i].wen;
      data_sram_addr = tbl[i].addr; data_sram_wdata = tbl[i].wdata;
      mem_ack = tbl[i].ack; mem_rdata = tbl[i].mrd;
      @(negedge clk);
      chk($sformatf("row%0d_req", i), mem_req, tbl[i].e_req);
      chk($sformatf("row%0d_stall", i), stallreq, tbl[i].e_st);
      chk($sformatf("row%0d_rdata", i), data_sram_rdata, tbl[i].e_rd);
      if (tbl[i].e_req) begin
        chk($sformatf("row%0d_bus", i), {mem_we, mem_be, mem_addr},
            {tbl[i].e_we, tbl[i].e_be, tbl[i].e_addr});
        chk($sformatf("row%0d_wdata", i), mem_wdata, tbl[i].e_wdata);
      end
      @(posedge clk);
      #1;
    end

    // Random traffic: each CPU request is held until taken by the bridge and the pipeline is not stalled.
    rst = 1'b0;
    m_busy = 1'b0; m_rd = 1'b0; m_we = 1'b0; m_be = '0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    cur_vld = 1'b0; cur_acc = 1'b0; cur_wen = '0; cur_addr = '0; cur_wdata = '0;
    wait_cnt = 0; loads = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!cur_vld && ($urandom_range(0, 9) < 7)) begin
        cur_vld   = 1'b1;
        cur_acc   = 1'b0;
        cur_wen   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        cur_addr  = $urandom;
        cur_wdata = $urandom;
      end
      data_sram_en    = cur_vld;
      data_sram_wen   = cur_vld ? cur_wen   : 4'($urandom);
      data_sram_addr  = cur_vld ? cur_addr  : 32'($urandom);
      data_sram_wdata = cur_vld ? cur_wdata : 32'($urandom);
      if (m_busy) begin
        wait_cnt++;
        mem_ack = (wait_cnt > 8) || ($urandom_range(0, 2) == 0);
      end else begin
        mem_ack = ($urandom_range(0, 7) == 0);
      end
      mem_rdata = $urandom;

      exp_st = (!m_busy && cur_vld && (cur_wen == 4'h0)) ||
               (m_busy && m_rd && !mem_ack) ||
               (m_busy && !m_rd && cur_vld && !mem_ack);

      @(negedge clk);
      chk("rnd_req", mem_req, m_busy);
      chk("rnd_stall", stallreq, exp_st);
      chk("rnd_rdata", data_sram_rdata, m_rdata);
      if (m_busy) begin
        chk("rnd_bus", {mem_we, mem_be, mem_addr}, {m_we, m_be, m_addr});
        chk("rnd_wdata", mem_wdata, m_wdata);
      end

      @(posedge clk);
      if (m_busy && mem_ack) begin
        if (m_rd) begin
          m_rdata = mem_rdata;
          loads++;
        end
        m_busy   = 1'b0;
        wait_cnt = 0;
      end else if (!m_busy && cur_vld) begin
        m_busy  = 1'b1;
        m_rd    = (cur_wen == 4'h0);
        m_we    = (cur_wen != 4'h0);
        m_be    = (cur_wen == 4'h0) ? 4'hF : cur_wen;
        m_addr  = {cur_addr[31:2], 2'b00};
        m_wdata = cur_wdata;
        cur_acc = 1'b1;
      end
      if (cur_vld && cur_acc && !exp_st) cur_vld = 1'b0;
      #1;
    end
    chk("rnd_loads_completed", 64'(loads > 50), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
